// File: rtl/mux2_share_arb_pkg.sv
// Shared types and defaults for the two-requester packet arbiter.
// MUX2_SHARE_ARB_PARITY_EN (default: undefined) adds the per-packet even-parity check.
package mux2_share_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DW_DEFAULT = 8;

  // Sole requester wins outright; on a tie the favoured requester wins.
  function automatic logic pick_winner(input logic [1:0] valid, input logic prio);
    return (valid == 2'b11) ? prio : valid[1];
  endfunction

endpackage

// File: rtl/mux2_share_arb_par_acc.sv
// Per-packet XOR-reduce accumulator; err pulses one cycle after a finishing beat
// whose packet carried an odd number of 1s.
module mux2_share_arb_par_acc #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          fin,
  input  logic [DW-1:0] data,
  output logic          err
);

  logic acc;
  logic beat_par;

  assign beat_par = ^data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= en & fin & (acc ^ beat_par);
      if (clr) begin
        acc <= 1'b0;
      end else if (en) begin
        acc <= acc ^ beat_par;
      end
    end
  end

endmodule

// File: rtl/mux2_share_arb.sv
// Round-robin owner of a shared 2:1 data mux, grant held for a whole packet.
// Define MUX2_SHARE_ARB_PARITY_EN to enable the even-parity check on par_err.
module mux2_share_arb
  import mux2_share_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_last,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic [1:0]    req_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  output logic          sel,
  output logic          busy,
  output logic          par_err
);

  state_t state;
  logic   owner;
  logic   prio;
  logic   hs;
  logic   hs_last;

  assign sel     = owner;
  assign out_src = owner;
  assign busy    = (state == ST_XFER);

  // Steering is purely combinational so an owned packet streams one beat per cycle.
  assign out_data  = sel ? req_data1 : req_data0;
  assign out_last  = sel ? req_last[1] : req_last[0];
  assign out_valid = busy & req_valid[owner];
  assign req_ready = busy ? (owner ? {out_ready, 1'b0} : {1'b0, out_ready}) : 2'b00;

  assign hs      = out_valid & out_ready;
  assign hs_last = hs & out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            state <= ST_XFER;
            owner <= pick_winner(req_valid, prio);
          end
        end
        ST_XFER: begin
          if (hs_last) begin
            state <= ST_IDLE;
            prio  <= ~owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX2_SHARE_ARB_PARITY_EN
  logic grant;

  assign grant = (state == ST_IDLE) & (|req_valid);

  mux2_share_arb_par_acc #(
    .DW(DW)
  ) u_par_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (grant),
    .en   (hs),
    .fin  (out_last),
    .data (out_data),
    .err  (par_err)
  );
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux2_share_arb.sv
// Directed scenarios followed by a randomized run checked against a packet-level reference model.
module tb_mux2_share_arb;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

`ifdef MUX2_SHARE_ARB_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_last;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_src;
  logic       sel;
  logic       busy;
  logic       par_err;

  int n_assert = 0;
  int n_fail   = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t b;
  int    len;
  int    cyc;
  logic  m_active;
  logic  m_owner;
  logic  m_prio;
  logic  m_par;
  logic  exp_pe;

  mux2_share_arb #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .sel       (sel),
    .busy      (busy),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset with arbitrary inputs applied
    rst = 1'b1;
    req_valid = 2'b11; req_last = 2'b01; req_data0 = 8'h5C; req_data1 = 8'hE7; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_par_err", par_err, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00; req_last = 2'b00;

    // Single requester: req1 three-beat packet
    @(negedge clk); req_valid = 2'b10; req_data1 = 8'h11; #1;
    chk("b_idle_busy", busy, 0);
    chk("b_idle_out_valid", out_valid, 0);
    @(negedge clk); #1;
    chk("b_busy", busy, 1);
    chk("b_sel", sel, 1);
    chk("b_out_src", out_src, 1);
    chk("b_beat0_data", out_data, 8'h11);
    chk("b_beat0_last", out_last, 0);
    chk("b_req_ready", req_ready, 2'b10);
    @(negedge clk); req_data1 = 8'h22; #1;
    chk("b_beat1_data", out_data, 8'h22);
    chk("b_beat1_valid", out_valid, 1);
    @(negedge clk); req_data1 = 8'h33; req_last = 2'b10; #1;
    chk("b_beat2_data", out_data, 8'h33);
    chk("b_beat2_last", out_last, 1);
    @(negedge clk); req_valid = 2'b00; req_last = 2'b00; #1;
    chk("b_after_busy", busy, 0);
    chk("b_after_par_err", par_err, 0);

    // Tie: both continuously request single-beat packets
    @(negedge clk); req_valid = 2'b11; req_last = 2'b11; req_data0 = 8'hA0; req_data1 = 8'hB1; #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      if (i % 2 == 0) begin
        chk("c_bubble_busy", busy, 0);
      end else begin
        chk("c_grant_busy", busy, 1);
        chk("c_grant_sel", sel, ((i - 1) / 2) % 2);
        chk("c_grant_data", out_data, ((i - 1) / 2) % 2 ? 8'hB1 : 8'hA0);
      end
    end

    // Backpressure on a req0 packet
    @(negedge clk); req_valid = 2'b01; req_last = 2'b00; req_data0 = 8'h5A; #1;
    chk("d_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); out_ready = 1'b0; #1;
      chk("d_stall_busy", busy, 1);
      chk("d_stall_sel", sel, 0);
      chk("d_stall_req_ready", req_ready, 0);
      chk("d_stall_data", out_data, 8'h5A);
      chk("d_stall_valid", out_valid, 1);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("d_resume_req_ready", req_ready, 2'b01);
    chk("d_resume_data", out_data, 8'h5A);
    @(negedge clk); req_data0 = 8'h5B; req_last = 2'b01; #1;
    chk("d_last_data", out_data, 8'h5B);
    chk("d_last_flag", out_last, 1);
    @(negedge clk); req_valid = 2'b00; req_last = 2'b00; #1;
    chk("d_after_busy", busy, 0);

    // Parity: odd packet then even packet
    @(negedge clk); req_valid = 2'b01; req_data0 = 8'h03; #1;
    @(negedge clk); #1;
    chk("e1_beat0_data", out_data, 8'h03);
    @(negedge clk); req_data0 = 8'h01; req_last = 2'b01; #1;
    chk("e1_before_par_err", par_err, 0);
    @(negedge clk); req_valid = 2'b00; req_last = 2'b00; #1;
    chk("e1_par_err_odd", par_err, PAR_ON);
    @(negedge clk); #1;
    chk("e1_par_err_pulse_end", par_err, 0);
    @(negedge clk); req_valid = 2'b01; req_data0 = 8'h03; #1;
    @(negedge clk); #1;
    @(negedge clk); req_last = 2'b01; #1;
    @(negedge clk); req_valid = 2'b00; req_last = 2'b00; #1;
    chk("e2_par_err_even", par_err, 0);

    // Reset mid-packet while req1 waits (prio favours req1 beforehand)
    @(negedge clk); req_valid = 2'b01; req_data0 = 8'h07; #1;
    chk("f_idle_busy", busy, 0);
    @(negedge clk); req_valid = 2'b11; req_data1 = 8'h0F; #1;
    chk("f_beat0_sel", sel, 0);
    @(negedge clk); req_data0 = 8'h08; #1;
    chk("f_beat1_data", out_data, 8'h08);
    #2 rst = 1'b1; #1;
    chk("f_rst_out_valid", out_valid, 0);
    chk("f_rst_req_ready", req_ready, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_sel", sel, 0);
    @(negedge clk); rst = 1'b0; req_data0 = 8'h03; req_last = 2'b11; #1;
    chk("f_post_idle", busy, 0);
    chk("f_post_par_err", par_err, 0);
    @(negedge clk); #1;
    chk("f_post_busy", busy, 1);
    chk("f_post_first_sel", sel, 0);
    @(negedge clk); #1;
    chk("f_post_bubble", busy, 0);
    chk("f_post_par_err2", par_err, 0);
    @(negedge clk); #1;
    chk("f_post_second_sel", sel, 1);
    @(negedge clk); req_valid = 2'b00; req_last = 2'b00; #1;
    chk("f_end_busy", busy, 0);
    chk("f_end_par_err", par_err, 0);

    // Randomized packets from both sources against the reference model
    for (int p = 0; p < 12; p++) begin
      for (int n = 0; n < 2; n++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          b.d = 8'($urandom);
          b.l = (k == len - 1);
          if (n == 0) q0.push_back(b);
          else        q1.push_back(b);
        end
      end
    end
    m_active = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_par = 1'b0; exp_pe = 1'b0; cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_active) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      req_valid[0] = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      req_valid[1] = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      if (q0.size() > 0) begin req_data0 = q0[0].d; req_last[0] = q0[0].l; end
      else begin req_data0 = 8'($urandom); req_last[0] = 1'($urandom); end
      if (q1.size() > 0) begin req_data1 = q1[0].d; req_last[1] = q1[0].l; end
      else begin req_data1 = 8'($urandom); req_last[1] = 1'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("r_par_err", par_err, exp_pe);
      exp_pe = 1'b0;
      if (!m_active) begin
        chk("r_idle_busy", busy, 0);
        chk("r_idle_out_valid", out_valid, 0);
        chk("r_idle_req_ready", req_ready, 0);
        if (req_valid != 2'b00) begin
          if (req_valid == 2'b01)      m_owner = 1'b0;
          else if (req_valid == 2'b10) m_owner = 1'b1;
          else                         m_owner = m_prio;
          m_active = 1'b1;
          m_par = 1'b0;
        end
      end else begin
        chk("r_busy", busy, 1);
        chk("r_sel", sel, m_owner);
        chk("r_out_valid", out_valid, req_valid[m_owner]);
        chk("r_req_ready", req_ready, out_ready ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
        if (req_valid[m_owner] && out_ready) begin
          b = m_owner ? q1.pop_front() : q0.pop_front();
          chk("r_data", out_data, b.d);
          chk("r_last", out_last, b.l);
          m_par = m_par ^ (^b.d);
          if (b.l) begin
            m_active = 1'b0;
            m_prio = ~m_owner;
            exp_pe = PAR_ON & m_par;
          end
        end
      end
    end
    @(negedge clk); req_valid = 2'b00; #1;
    chk("r_final_par_err", par_err, exp_pe);
    chk("r_drained", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
